// File: rtl/idu_sched.sv
// IncDec-unit scheduler: arbitrates PC/SP/HL step requests onto the shared IDU, plus IE-load edge detect.
// Build option IDU_SCHED_RR_EN selects round-robin arbitration; otherwise fixed priority SP > HL > PC.
module idu_sched (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       pc_req,
  input  logic       sp_req,
  input  logic       sp_dec,
  input  logic       sp_two,
  input  logic       hl_req,
  input  logic       hl_dec,
  input  logic       stall,
  input  logic       ie_hit,
  input  logic       wr,
  output logic       idu_inc,
  output logic       idu_dec,
  output logic       idu_pair,
  output logic [1:0] idu_sel,
  output logic       pc_gnt,
  output logic       sp_gnt,
  output logic       hl_gnt,
  output logic       busy,
  output logic       ie_load
);
  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, STEP2 = 2'd2} state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_PC   = 2'd1;
  localparam logic [1:0] SEL_SP   = 2'd2;
  localparam logic [1:0] SEL_HL   = 2'd3;

  state_t     state_q, state_d;
  logic [1:0] win_q, win_d;
  logic       dir_q, dir_d;
  logic       two_q, two_d;
  logic       arm_q;
  logic       idu_inc_q, idu_inc_d;
  logic       idu_dec_q, idu_dec_d;
  logic       idu_pair_q, idu_pair_d;
  logic [1:0] idu_sel_q, idu_sel_d;
  logic       pc_gnt_q, pc_gnt_d;
  logic       sp_gnt_q, sp_gnt_d;
  logic       hl_gnt_q, hl_gnt_d;
  logic       busy_q, busy_d;
  logic       ie_load_q, ie_load_d;
  logic       ie_prev_q;
  logic [2:0] req_m;
  logic [1:0] pick;
  logic       gnt_now, arb, act, fin, ie_lvl;

  // Returns the first requesting source in the order p0, p1, p2 (r is indexed by sel code - 1).
  function automatic logic [1:0] first_req(input logic [2:0] r, input logic [1:0] p0,
                                           input logic [1:0] p1, input logic [1:0] p2);
    logic [1:0] res;
    res = SEL_NONE;
    if (r[p2 - 2'd1]) res = p2;
    if (r[p1 - 2'd1]) res = p1;
    if (r[p0 - 2'd1]) res = p0;
    return res;
  endfunction

  assign gnt_now = pc_gnt_q | sp_gnt_q | hl_gnt_q;

  // The requester granted this cycle still holds its request, so hide it from the re-arbitration.
  always_comb begin
    req_m = {hl_req, sp_req, pc_req};
    if (gnt_now && (win_q != SEL_NONE)) req_m[win_q - 2'd1] = 1'b0;
  end

`ifdef IDU_SCHED_RR_EN
  logic [1:0] last_q, last_d;

  always_comb begin
    case (last_q)
      SEL_SP:  pick = first_req(req_m, SEL_HL, SEL_PC, SEL_SP);
      SEL_HL:  pick = first_req(req_m, SEL_PC, SEL_SP, SEL_HL);
      default: pick = first_req(req_m, SEL_SP, SEL_HL, SEL_PC);
    endcase
    last_d = (arb && (pick != SEL_NONE)) ? pick : last_q;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) last_q <= SEL_PC;
    else         last_q <= last_d;
  end
`else
  always_comb pick = first_req(req_m, SEL_SP, SEL_HL, SEL_PC);
`endif

  // idu_pair_q tells whether the current state's step really happened or was frozen by stall.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    dir_d   = dir_q;
    two_d   = two_q;
    arb     = 1'b0;
    case (state_q)
      IDLE: arb = arm_q && !stall;
      STEP, STEP2: begin
        if (idu_pair_q) begin
          if (!gnt_now)   state_d = STEP2;
          else if (stall) state_d = IDLE;
          else            arb = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      if (pick == SEL_NONE) begin
        state_d = IDLE;
      end else begin
        state_d = STEP;
        win_d   = pick;
        dir_d   = (pick == SEL_SP) ? sp_dec : (pick == SEL_HL) ? hl_dec : 1'b0;
        two_d   = (pick == SEL_SP) && sp_two;
      end
    end
  end

  always_comb begin
    act        = (state_d != IDLE) && !stall;
    fin        = act && ((state_d == STEP2) || !two_d);
    idu_sel_d  = (state_d == IDLE) ? SEL_NONE : win_d;
    idu_pair_d = act;
    idu_inc_d  = act && !dir_d;
    idu_dec_d  = act && dir_d;
    pc_gnt_d   = fin && (win_d == SEL_PC);
    sp_gnt_d   = fin && (win_d == SEL_SP);
    hl_gnt_d   = fin && (win_d == SEL_HL);
    busy_d     = (state_d != IDLE);
    ie_lvl     = ie_hit & wr;
    ie_load_d  = ie_lvl & ~ie_prev_q;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      win_q      <= SEL_NONE;
      dir_q      <= 1'b0;
      two_q      <= 1'b0;
      arm_q      <= 1'b0;
      idu_inc_q  <= 1'b0;
      idu_dec_q  <= 1'b0;
      idu_pair_q <= 1'b0;
      idu_sel_q  <= SEL_NONE;
      pc_gnt_q   <= 1'b0;
      sp_gnt_q   <= 1'b0;
      hl_gnt_q   <= 1'b0;
      busy_q     <= 1'b0;
      ie_load_q  <= 1'b0;
      ie_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      dir_q      <= dir_d;
      two_q      <= two_d;
      arm_q      <= 1'b1;
      idu_inc_q  <= idu_inc_d;
      idu_dec_q  <= idu_dec_d;
      idu_pair_q <= idu_pair_d;
      idu_sel_q  <= idu_sel_d;
      pc_gnt_q   <= pc_gnt_d;
      sp_gnt_q   <= sp_gnt_d;
      hl_gnt_q   <= hl_gnt_d;
      busy_q     <= busy_d;
      ie_load_q  <= ie_load_d;
      ie_prev_q  <= ie_lvl;
    end
  end

  assign idu_inc  = idu_inc_q;
  assign idu_dec  = idu_dec_q;
  assign idu_pair = idu_pair_q;
  assign idu_sel  = idu_sel_q;
  assign pc_gnt   = pc_gnt_q;
  assign sp_gnt   = sp_gnt_q;
  assign hl_gnt   = hl_gnt_q;
  assign busy     = busy_q;
  assign ie_load  = ie_load_q;
endmodule

// File: doc/idu_sched.md
IDU_SCHED -- requirements
Module: idu_sched

Interface
REQ-001 SHALL provide port CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide port nRESET  input  1  asynchronous active-low reset.
REQ-003 SHALL provide port pc_req  input  1  PC increment request, held until pc_gnt.
REQ-004 SHALL provide port sp_req  input  1  SP step request, held until sp_gnt.
REQ-005 SHALL provide port sp_dec  input  1  1: SP decrement; 0: SP increment; sampled with sp_req.
REQ-006 SHALL provide port sp_two  input  1  1: two SP steps (push/pop pair); sampled with sp_req.
REQ-007 SHALL provide port hl_req  input  1  HL post-step request, held until hl_gnt.
REQ-008 SHALL provide port hl_dec  input  1  1: HL decrement; 0: HL increment.
REQ-009 SHALL provide port stall  input  1  freeze sequencing.
REQ-010 SHALL provide port ie_hit  input  1  IE address (0xFFFF) decoded.
REQ-011 SHALL provide port wr  input  1  bus write strobe.
REQ-012 SHALL provide port idu_inc / idu_dec / idu_pair  output  1 each  IncDec unit controls.
REQ-013 SHALL provide port idu_sel  output  2  operand pair: 00 none, 01 PC, 10 SP, 11 HL.
REQ-014 SHALL provide port pc_gnt / sp_gnt / hl_gnt  output  1 each  one-cycle completion pulses.
REQ-015 SHALL provide port busy  output  1  FSM not in IDLE.
REQ-016 SHALL provide port ie_load  output  1  load IE register from DL bus.

Function
REQ-017 SHALL implement FSM states IDLE, STEP, STEP2; all outputs registered.
REQ-018 SHALL, in IDLE with stall=0 and any request, latch winner and direction and enter STEP next edge (request-to-control latency 1 cycle).
REQ-019 SHALL, in STEP, drive idu_pair=1, idu_sel=winner, exactly one of idu_inc/idu_dec (PC always inc).
REQ-020 SHALL pulse the winner's gnt in STEP, except SP with sp_two=1, which goes STEP -> STEP2 and pulses sp_gnt in STEP2 only.
REQ-021 SHALL repeat the same SP direction in STEP2 (two consecutive IDU cycles).
REQ-022 SHALL arbitrate again in the cycle a gnt is high, masking the just-granted requester, so back-to-back grants need no idle cycle; with no remaining request, return to IDLE.
REQ-023 SHALL ignore request deassertion mid-sequence; latched sequence completes.
REQ-024 SHALL, while stall=1, hold state and latched winner, force idu_inc/idu_dec/idu_pair and all gnt to 0, keep idu_sel; resume in the same state after stall drops.
REQ-025 SHALL never assert idu_inc and idu_dec together, nor more than one gnt per cycle.
REQ-026 SHALL drive idu_sel=00 and idu_* = 0 in IDLE.
REQ-027 SHALL assert ie_load for one cycle on the first edge where ie_hit & wr rises from 0 to 1; a held level yields one pulse; ie_load is independent of stall and FSM.

Reset
REQ-028 SHALL on nRESET=0 immediately force state IDLE, all outputs 0, idu_sel=00, round-robin pointer to PC, ie_load edge history to 0.
REQ-029 SHALL abort any sequence in progress (including STEP2) without gnt; first post-reset grant no earlier than the second rising edge after release.

Configuration
REQ-030 SHALL use macro IDU_SCHED_RR_EN: defined -> round-robin among PC, SP, HL (pointer advances past each winner); undefined -> fixed priority SP > HL > PC.

Verification
REQ-031 SHALL cover: pc_req=1 alone -> 1 cycle later idu_sel=01, idu_inc=1, idu_pair=1, pc_gnt=1 for 1 cycle.
REQ-032 SHALL cover: sp_req=1, sp_dec=1, sp_two=1 -> two consecutive cycles idu_sel=10, idu_dec=1; sp_gnt only in second.
REQ-033 SHALL cover: pc_req, sp_req, hl_req all held -> RR build grants SP,HL,PC rotation with no idle gaps; fixed build grants SP then HL then PC.
REQ-034 SHALL cover: stall=1 in STEP2 for 3 cycles -> idu_*=0, gnt=0, idu_sel=10 held; STEP2 completes cycle after stall=0.
REQ-035 SHALL cover: nRESET low during STEP2 -> outputs 0 asynchronously, no sp_gnt; ie_hit=1,wr=1 held 4 cycles -> single ie_load pulse.
